result_unload: RTL

Output-side serializer for the MLP accelerator. It buffers the final 16×16 matrix of 16-bit results, written one 256-bit row at a time from the round-result store, then streams it to the host as 32-bit payloads over a valid/ready handshake. It is the transmit counterpart of the 32-bit `dataload` input path and supplies `result_valid_o` / `result_payload_o` at the accelerator top.

---
 rtl/result_unload.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/result_unload.sv
// result_unload: buffers a ROWS x COLS matrix of DW-bit results and streams it out as 2*DW-bit beats
// over valid/ready. Optional macro RESULT_UNLOAD_CHKSUM_EN appends an XOR checksum beat.
module result_unload #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16,
    parameter int unsigned DW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      row_we_i,
    input  logic [$clog2(ROWS)-1:0]   row_idx_i,
    input  logic [COLS*DW-1:0]        row_data_i,
    input  logic                      start_i,
    input  logic                      result_ready_i,
    output logic                      result_valid_o,
    output logic [2*DW-1:0]           result_payload_o,
    output logic                      result_last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      wr_err_o
);

    localparam int unsigned ROWW  = COLS * DW;
    localparam int unsigned PAYW  = 2 * DW;
    localparam int unsigned PPR   = COLS / 2;
    localparam int unsigned NBEAT = ROWS * PPR;
    localparam int unsigned PW    = $clog2(PPR);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned BW    = $clog2(NBEAT);
`ifdef RESULT_UNLOAD_CHKSUM_EN
    localparam int unsigned TOTAL = NBEAT + 1;
`else
    localparam int unsigned TOTAL = NBEAT;
`endif
    localparam int unsigned KW    = $clog2(TOTAL);
    localparam logic [KW-1:0] LAST_K = KW'(TOTAL - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e             state_q;
    logic [KW-1:0]      k_q;
    logic [ROWW-1:0]    mem_q [ROWS];
    logic               valid_q;
    logic [PAYW-1:0]    payload_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;
    logic               wr_err_q;
`ifdef RESULT_UNLOAD_CHKSUM_EN
    logic [PAYW-1:0]    chk_q;
`endif

    logic [BW-1:0]      beat_idx_d;
    logic [RW-1:0]      rd_row_d;
    logic [PW-1:0]      rd_pair_d;
    logic [PAYW-1:0]    beat_payload_d;
    logic [KW-1:0]      k_inc_d;
    logic               hs_c;

    // Prefetch of the beat that the output register loads next: beat 0 in IDLE, beat k+1 in SEND.
    always_comb begin
        k_inc_d        = k_q + KW'(1);
        beat_idx_d     = (state_q == ST_SEND) ? BW'(k_inc_d) : '0;
        rd_row_d       = beat_idx_d[PW +: RW];
        rd_pair_d      = beat_idx_d[PW-1:0];
        beat_payload_d = mem_q[rd_row_d][rd_pair_d*PAYW +: PAYW];
        hs_c           = valid_q && result_ready_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            valid_q   <= 1'b0;
            payload_q <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
`ifdef RESULT_UNLOAD_CHKSUM_EN
            chk_q     <= '0;
`endif
            for (int i = 0; i < int'(ROWS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A write in the same cycle as start wins; the start is dropped.
                    if (row_we_i) begin
                        mem_q[row_idx_i] <= row_data_i;
                    end else if (start_i) begin
                        state_q   <= ST_SEND;
                        k_q       <= '0;
                        valid_q   <= 1'b1;
                        payload_q <= beat_payload_d;
                        last_q    <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef RESULT_UNLOAD_CHKSUM_EN
                        chk_q     <= '0;
`endif
                    end
                end
                ST_SEND: begin
                    if (row_we_i) begin
                        wr_err_q <= 1'b1;
                    end
                    if (hs_c) begin
`ifdef RESULT_UNLOAD_CHKSUM_EN
                        chk_q <= chk_q ^ payload_q;
`endif
                        if (k_q == LAST_K) begin
                            state_q   <= ST_IDLE;
                            k_q       <= '0;
                            valid_q   <= 1'b0;
                            payload_q <= '0;
                            last_q    <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
`ifdef RESULT_UNLOAD_CHKSUM_EN
                        else if (k_q == KW'(NBEAT - 1)) begin
                            k_q       <= k_inc_d;
                            payload_q <= chk_q ^ payload_q;
                            last_q    <= 1'b1;
                        end
`endif
                        else begin
                            k_q       <= k_inc_d;
                            payload_q <= beat_payload_d;
                            last_q    <= (k_inc_d == LAST_K);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result_valid_o   = valid_q;
    assign result_payload_o = payload_q;
    assign result_last_o    = last_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign wr_err_o         = wr_err_q;

endmodule
